// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the fetch unit, the memory
// controller and the memory stage.
//   ADDR_W   : RAM address width (half-word addressed).
//   WORD_W   : instruction / data word width.
//   RESET_PC : PC value loaded at reset (must be even).
//   PC_STEP  : PC increment per fetched word (one word = two half-words).
//   fetch_state_e : instruction-fetch FSM encoding.
package cpu_pkg;

  localparam int ADDR_W = 18;
  localparam int WORD_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 18'h00000;
  localparam logic [ADDR_W-1:0] PC_STEP  = 18'd2;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/pc_reg.sv
// pc_reg: program counter with load (redirect), increment and natural wrap.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous, active-low; loads RESET_PC
//   load   : load the target address (takes priority over inc)
//   inc    : advance by PC_STEP, wrapping modulo 2^ADDR_W
//   target : load address; bit 0 is forced to 0
//   pc     : current program counter
module pc_reg
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_target_even;

  // Word fetches are always at even half-word addresses.
  assign w_target_even = target & {{(ADDR_W-1){1'b1}}, 1'b0};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values that existed before the clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (load) begin
      r_pc <= w_target_even;
    end else if (inc) begin
      // 18'h3FFFE + 2 drops the carry and wraps to 0.
      r_pc <= r_pc + PC_STEP;
    end
  end

  assign pc = r_pc;

endmodule : pc_reg

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the PC, issues word requests on
// the memory controller fetch port and hands fetched words to decode through
// a single-entry output register with stall and branch-redirect handling.
// Ports:
//   clock, reset             : rising-edge clock, async active-low reset
//   if_mc_en, if_mc_addr     : fetch request / half-word address (combinational)
//   mc_if_data, mc_if_ack    : fetched word, valid on the acknowledge cycle
//   id_if_stall              : decode cannot accept a new instruction
//   ex_if_branch/_target     : redirect request and target address
//   if_id_instr/_pc/_valid   : registered instruction, its address and valid
module fetch_unit
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  output logic              if_mc_en,
  output logic [ADDR_W-1:0] if_mc_addr,
  input  logic [WORD_W-1:0] mc_if_data,
  input  logic              mc_if_ack,
  input  logic              id_if_stall,
  input  logic              ex_if_branch,
  input  logic [ADDR_W-1:0] ex_if_target,
  output logic [WORD_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic              if_id_valid
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [WORD_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_valid;

  logic [ADDR_W-1:0] w_pc;
  logic              w_accept;
  logic              w_branch;
  logic              w_ack_take;

  // The output register can take a new word when it is empty or being
  // consumed this cycle.
  assign w_accept = !r_valid || !id_if_stall;

  // Redirects are ignored while booting.
  assign w_branch = ex_if_branch && (r_state != BOOT);

  // An ack only counts against a live request; a same-cycle branch drops it.
  assign w_ack_take = if_mc_en && mc_if_ack && !w_branch;

  pc_reg u_pc_reg (
    .clock  (clock),
    .reset  (reset),
    .load   (w_branch),
    .inc    (w_ack_take),
    .target (ex_if_target),
    .pc     (w_pc)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. REDIRECT keeps the request low for one cycle so the
  // controller can abandon a partially completed two-half access; a further
  // branch there restarts that cycle.
  // NOTE: every combinational output gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BOOT:     w_state_next = RUN;
      RUN:      if (w_branch) w_state_next = REDIRECT;
      REDIRECT: w_state_next = w_branch ? REDIRECT : RUN;
      default:  w_state_next = BOOT;
    endcase
  end

  // Output logic: request whenever running and the output register can
  // accept; the address is the PC so it stays stable until ack or redirect.
  always_comb begin
    if_mc_en   = 1'b0;
    if_mc_addr = w_pc;
    if (r_state == RUN) begin
      if_mc_en = w_accept;
    end
  end

  // Output register toward decode.
  // NOTE: the data/pc fields are reset too, so decode sees zeros (not X)
  // straight out of reset even though valid already qualifies them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else if (w_branch) begin
      r_valid <= 1'b0;
    end else if (w_ack_take) begin
      r_instr    <= mc_if_data;
      r_instr_pc <= w_pc;
      r_valid    <= 1'b1;
    end else if (!id_if_stall) begin
      // Entry consumed with nothing to replace it.
      r_valid <= 1'b0;
    end
  end

  assign if_id_instr = r_instr;
  assign if_id_pc    = r_instr_pc;
  assign if_id_valid = r_valid;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit. A small RAM
// model answers the fetch port; inputs change and outputs are sampled 1 ns
// after the rising edge.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic              clock;
  logic              reset;
  logic              if_mc_en;
  logic [ADDR_W-1:0] if_mc_addr;
  logic [WORD_W-1:0] mc_if_data;
  logic              mc_if_ack;
  logic              id_if_stall;
  logic              ex_if_branch;
  logic [ADDR_W-1:0] ex_if_target;
  logic [WORD_W-1:0] if_id_instr;
  logic [ADDR_W-1:0] if_id_pc;
  logic              if_id_valid;

  int n_compared   = 0;
  int n_mismatched = 0;

  fetch_unit dut (
    .clock        (clock),
    .reset        (reset),
    .if_mc_en     (if_mc_en),
    .if_mc_addr   (if_mc_addr),
    .mc_if_data   (mc_if_data),
    .mc_if_ack    (mc_if_ack),
    .id_if_stall  (id_if_stall),
    .ex_if_branch (ex_if_branch),
    .ex_if_target (ex_if_target),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .if_id_valid  (if_id_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [WORD_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    return 32'hC0DE_0000 ^ {14'h0, a};
  endfunction

  // RAM model: the word at the requested address is always on the bus; the
  // bench decides when to acknowledge.
  assign mc_if_data = ram_word(if_mc_addr);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_req(input string tag, input logic en,
                           input logic [ADDR_W-1:0] addr);
    check({tag, ".en"}, 32'(if_mc_en), 32'(en));
    check({tag, ".addr"}, 32'(if_mc_addr), 32'(addr));
  endtask

  task automatic check_out(input string tag, input logic valid,
                           input logic [ADDR_W-1:0] pc,
                           input logic [WORD_W-1:0] instr);
    check({tag, ".valid"}, 32'(if_id_valid), 32'(valid));
    check({tag, ".pc"}, 32'(if_id_pc), 32'(pc));
    check({tag, ".instr"}, if_id_instr, instr);
  endtask

  initial begin
    reset        = 1'b0;
    mc_if_ack    = 1'b0;
    id_if_stall  = 1'b0;
    ex_if_branch = 1'b0;
    ex_if_target = '0;

    // Reset state.
    #12;
    check_req("rst", 1'b0, RESET_PC);
    check_out("rst", 1'b0, 18'h0, 32'h0);

    // Release between edges; a branch during BOOT must be ignored.
    #10 reset = 1'b1;
    ex_if_branch = 1'b1;
    ex_if_target = 18'h00200;
    check_req("boot", 1'b0, 18'h0);
    tick();
    ex_if_branch = 1'b0;
    #1;
    check_req("run0", 1'b1, 18'h0);
    check("run0.valid", 32'(if_id_valid), 32'd0);

    // Controller acks every cycle: requests 0,2,4, output follows by one.
    mc_if_ack = 1'b1;
    tick();
    check_req("seq1", 1'b1, 18'h2);
    check_out("seq1", 1'b1, 18'h0, ram_word(18'h0));
    tick();
    check_req("seq2", 1'b1, 18'h4);
    check_out("seq2", 1'b1, 18'h2, ram_word(18'h2));

    // Memory stage holds the RAM for 3 cycles.
    mc_if_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_req("wait", 1'b1, 18'h4);
      check("wait.valid", 32'(if_id_valid), 32'd0);
    end
    mc_if_ack = 1'b1;
    tick();
    check_req("late", 1'b1, 18'h6);
    check_out("late", 1'b1, 18'h4, ram_word(18'h4));

    // Decode stalls 4 cycles with a valid entry; a stray ack is ignored.
    id_if_stall = 1'b1;
    #1;
    check_req("stall0", 1'b0, 18'h6);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_req("stall", 1'b0, 18'h6);
      check_out("stall", 1'b1, 18'h4, ram_word(18'h4));
    end
    id_if_stall = 1'b0;
    #1;
    check_req("resume0", 1'b1, 18'h6);
    tick();
    check_req("resume", 1'b1, 18'h8);
    check_out("resume", 1'b1, 18'h6, ram_word(18'h6));

    // Branch to an odd target in the same cycle as an ack for address 8.
    ex_if_branch = 1'b1;
    ex_if_target = 18'h00101;
    tick();
    ex_if_branch = 1'b0;
    #1;
    check_req("br", 1'b0, 18'h00100);
    check("br.valid", 32'(if_id_valid), 32'd0);
    check("br.pc", 32'(if_id_pc), 32'h6);
    tick();
    check_req("br_req", 1'b1, 18'h00100);
    tick();
    check_req("br_next", 1'b1, 18'h00102);
    check_out("br_out", 1'b1, 18'h00100, ram_word(18'h00100));

    // Branch near the top, then again during REDIRECT; then wrap.
    mc_if_ack    = 1'b0;
    ex_if_branch = 1'b1;
    ex_if_target = 18'h00300;
    tick();
    check_req("redir1", 1'b0, 18'h00300);
    ex_if_target = 18'h3FFFF;
    tick();
    ex_if_branch = 1'b0;
    #1;
    check_req("redir2", 1'b0, 18'h3FFFE);
    check("redir2.valid", 32'(if_id_valid), 32'd0);
    tick();
    check_req("top_req", 1'b1, 18'h3FFFE);
    mc_if_ack = 1'b1;
    tick();
    check_req("wrap", 1'b1, 18'h00000);
    check_out("wrap", 1'b1, 18'h3FFFE, ram_word(18'h3FFFE));
    tick();
    check_req("pend", 1'b1, 18'h00002);

    // Reset in the middle of a pending request for address 2.
    mc_if_ack = 1'b0;
    tick();
    check_req("pend2", 1'b1, 18'h00002);
    mc_if_ack = 1'b1;
    #2 reset = 1'b0;
    #1;
    check_req("mid_rst", 1'b0, RESET_PC);
    check_out("mid_rst", 1'b0, 18'h0, 32'h0);
    tick();
    check_req("mid_rst_hold", 1'b0, RESET_PC);
    check("mid_rst_hold.valid", 32'(if_id_valid), 32'd0);
    #2 reset = 1'b1;
    tick();
    check_req("rerun", 1'b1, RESET_PC);
    tick();
    check_req("rerun1", 1'b1, 18'h00002);
    check_out("rerun1", 1'b1, RESET_PC, ram_word(RESET_PC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_fetch_unit
